// File: rtl/alu_logic_pkg.sv
// -----------------------------------------------------------------------------
// alu_logic_pkg
// Shared definitions for the logic/shift unit and every block that issues
// operations to it.
//   alu_logic_op_t : 3-bit operation select encoding
//   ALU_LOGIC_OPS  : number of distinct operation encodings
// -----------------------------------------------------------------------------
package alu_logic_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOT  = 3'b011,
        OP_LSL  = 3'b100,
        OP_LSR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_ZERO = 3'b111
    } alu_logic_op_t;

    localparam int ALU_LOGIC_OPS = 8;

    // Shift operations only look at the low bits of B as the shift amount.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/alu_logic_arbiter_unit.sv
// -----------------------------------------------------------------------------
// ALULogicModule
// Purely combinational logic/shift unit.
//   a, b : operands (bits wide)
//   op   : operation select (alu_logic_op_t encoding)
//   y    : result (bits wide)
// Shift amounts use the low $clog2(bits) bits of b, so a shift never exceeds
// the operand width.
// -----------------------------------------------------------------------------
module ALULogicModule
    import alu_logic_pkg::*;
#(
    parameter int bits = 32
) (
    input  logic [bits-1:0] a,
    input  logic [bits-1:0] b,
    input  logic [2:0]      op,
    output logic [bits-1:0] y
);

    localparam int SHIFT_W = (bits > 1) ? $clog2(bits) : 1;

    logic [SHIFT_W-1:0] shamt;

    assign shamt = b[SHIFT_W-1:0];

    // Decode the operation and produce the result.
    always_comb begin
        y = '0;
        case (alu_logic_op_t'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_LSL:  y = a << shamt;
            OP_LSR:  y = a >> shamt;
            OP_ASR:  y = $unsigned($signed(a) >>> shamt);
            OP_ZERO: y = '0;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_logic_arbiter.sv
// -----------------------------------------------------------------------------
// alu_logic_arbiter
// Shares one ALULogicModule between two requesters using round-robin
// arbitration and captures each accepted result in a single-entry output
// register tagged with the requester ID.
//   clk, rst                       : clock, synchronous active-high reset
//   req0_valid/ready/a/b/op        : requester 0 handshake and payload
//   req1_valid/ready/a/b/op        : requester 1 handshake and payload
//   res_valid/ready                : result handshake (backpressured)
//   res_y                          : registered result
//   res_id                         : requester that produced res_y
// -----------------------------------------------------------------------------
module alu_logic_arbiter
    import alu_logic_pkg::*;
#(
    parameter int bits = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [bits-1:0] req0_a,
    input  logic [bits-1:0] req0_b,
    input  logic [2:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [bits-1:0] req1_a,
    input  logic [bits-1:0] req1_b,
    input  logic [2:0]      req1_op,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [bits-1:0] res_y,
    output logic            res_id
);

    logic            res_valid_q, res_valid_d;
    logic [bits-1:0] res_y_q, res_y_d;
    logic            res_id_q, res_id_d;
    logic            last_q, last_d;

    logic            grant0, grant1;
    logic            can_accept;
    logic            accept;
    logic [bits-1:0] unit_a, unit_b, unit_y;
    logic [2:0]      unit_op;

    // Round-robin grant: a lone requester always wins; under contention the
    // port that was not served last wins. Ready is held low during reset so no
    // requester believes it was accepted by a cycle that gets discarded.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_q);
        grant1     = req1_valid && (!req0_valid || !last_q);
        can_accept = !res_valid_q || res_ready;
        req0_ready = grant0 && can_accept && !rst;
        req1_ready = grant1 && can_accept && !rst;
        accept     = req0_ready || req1_ready;
    end

    // The operand mux follows the grant so the unit always sees the payload
    // of the port that may be accepted this cycle.
    always_comb begin
        unit_a  = grant1 ? req1_a  : req0_a;
        unit_b  = grant1 ? req1_b  : req0_b;
        unit_op = grant1 ? req1_op : req0_op;
    end

    ALULogicModule #(
        .bits (bits)
    ) u_logic (
        .a  (unit_a),
        .b  (unit_b),
        .op (unit_op),
        .y  (unit_y)
    );

    // Output register update. An accept always wins over a plain drain, which
    // gives back-to-back results with no bubble. A drain alone only clears the
    // valid flag; the stale data and ID stay put, and the round-robin pointer
    // only moves when something is accepted.
    always_comb begin
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_id_d    = res_id_q;
        last_d      = last_q;
        if (accept) begin
            res_valid_d = 1'b1;
            res_y_d     = unit_y;
            res_id_d    = grant1;
            last_d      = grant1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // State registers. Reset points 'last' at port 1 so port 0 wins the
    // first contention after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_id_q    <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_id_q    <= res_id_d;
            last_q      <= last_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_logic_arbiter
// Directed bench for alu_logic_arbiter with a behavioural reference model and
// a per-cycle comparison against it.
// -----------------------------------------------------------------------------
module tb_alu_logic_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_op;
    logic        res_valid, res_ready;
    logic [31:0] res_y;
    logic        res_id;

    int checks   = 0;
    int failures = 0;

    logic        cmp_en = 1'b0;
    logic        seen_ready0, seen_ready1;

    // Reference model state: what the result port must show.
    logic        m_valid;
    logic [31:0] m_y;
    logic        m_id;
    logic        m_last;

    alu_logic_arbiter #(
        .bits (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_y      (res_y),
        .res_id     (res_id)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference semantics of the logic unit for a 32-bit datapath.
    function automatic logic [31:0] refOp(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~a;
            3'd4: return a << sh;
            3'd5: return a >> sh;
            3'd6: return 32'($signed(a) >>> sh);
            default: return 32'h0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    // Model update: decide who wins, whether the output register can take a
    // new result, and what the register holds afterwards.
    always @(posedge clk) begin
        logic win0, win1, room;
        if (rst) begin
            m_valid = 1'b0;
            m_y     = 32'h0;
            m_id    = 1'b0;
            m_last  = 1'b1;
        end else begin
            win0 = req0_valid && (!req1_valid || m_last == 1'b1);
            win1 = req1_valid && (!req0_valid || m_last == 1'b0);
            room = !m_valid || res_ready;
            if ((win0 || win1) && room) begin
                m_valid = 1'b1;
                m_y     = win1 ? refOp(req1_op, req1_a, req1_b) : refOp(req0_op, req0_a, req0_b);
                m_id    = win1;
                m_last  = win1;
            end else if (m_valid && res_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic e0, e1, room;
        if (cmp_en) begin
            room = !m_valid || res_ready;
            e0 = !rst && room && req0_valid && (!req1_valid || m_last == 1'b1);
            e1 = !rst && room && req1_valid && (!req0_valid || m_last == 1'b0);
            checkOutput("cmp_res_valid", 32'(res_valid), 32'(m_valid));
            checkOutput("cmp_res_y", res_y, m_y);
            checkOutput("cmp_res_id", 32'(res_id), 32'(m_id));
            checkOutput("cmp_req0_ready", 32'(req0_ready), 32'(e0));
            checkOutput("cmp_req1_ready", 32'(req1_ready), 32'(e1));
        end
    end

    // Drive one cycle of inputs, record the readies mid-cycle, then step past
    // the next rising edge so the registered outputs reflect this cycle.
    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [2:0] op0, input logic v1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic [2:0] op1,
                                 input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        res_ready  = rr;
        #2;
        seen_ready0 = req0_ready;
        seen_ready1 = req1_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic rr);
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 3'd0, rr);
    endtask

    // Both ports valid: port 0 asks for 1|2, port 1 asks for 1<<4.
    task automatic contendCycle(input logic rr);
        applyStimulus(1'b1, 32'h1, 32'h2, 3'd1, 1'b1, 32'h1, 32'h4, 3'd4, rr);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        v0, v1, rr;

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        res_ready  = 1'b0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        idleCycle(1'b0);
        rst = 1'b0;

        // Single port request.
        applyStimulus(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        checkOutput("single_valid", 32'(res_valid), 32'h1);
        checkOutput("single_y", res_y, 32'h00F0_00F0);
        checkOutput("single_id", 32'(res_id), 32'h0);
        idleCycle(1'b1);
        checkOutput("single_drain_valid", 32'(res_valid), 32'h0);

        // Reset, then contention: port 0 first, then alternating.
        rst = 1'b1;
        idleCycle(1'b1);
        rst = 1'b0;
        checkOutput("reset_y", res_y, 32'h0);
        contendCycle(1'b1);
        checkOutput("contend1_id", 32'(res_id), 32'h0);
        checkOutput("contend1_y", res_y, 32'h3);
        contendCycle(1'b1);
        checkOutput("contend2_id", 32'(res_id), 32'h1);
        checkOutput("contend2_y", res_y, 32'h10);
        contendCycle(1'b1);
        checkOutput("contend3_id", 32'(res_id), 32'h0);
        contendCycle(1'b1);
        checkOutput("contend4_id", 32'(res_id), 32'h1);
        idleCycle(1'b1);

        // Backpressure while holding 0xFF, then same-cycle drain and refill.
        applyStimulus(1'b1, 32'hF0, 32'h0F, 3'd1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        checkOutput("bp_fill_y", res_y, 32'hFF);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hF0, 32'h0F, 3'd1, 1'b1, 32'h8000_0000, 32'h4, 3'd6, 1'b0);
            checkOutput("bp_ready0", 32'(seen_ready0), 32'h0);
            checkOutput("bp_ready1", 32'(seen_ready1), 32'h0);
            checkOutput("bp_hold_y", res_y, 32'hFF);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h8000_0000, 32'h4, 3'd6, 1'b1);
        checkOutput("refill_ready1", 32'(seen_ready1), 32'h1);
        checkOutput("refill_y", res_y, 32'hF800_0000);
        checkOutput("refill_id", 32'(res_id), 32'h1);

        // Drain only; the pointer still favours port 0 afterwards.
        idleCycle(1'b1);
        checkOutput("drain_valid", 32'(res_valid), 32'h0);
        checkOutput("drain_stale_y", res_y, 32'hF800_0000);
        contendCycle(1'b1);
        checkOutput("post_drain_id", 32'(res_id), 32'h0);
        idleCycle(1'b1);

        // Reset while FULL and stalled.
        applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h5, 32'h3, 3'd2, 1'b0);
        checkOutput("mid_fill_y", res_y, 32'h6);
        checkOutput("mid_fill_id", 32'(res_id), 32'h1);
        contendCycle(1'b0);
        rst = 1'b1;
        contendCycle(1'b0);
        checkOutput("rst_ready0", 32'(seen_ready0), 32'h0);
        checkOutput("rst_ready1", 32'(seen_ready1), 32'h0);
        rst = 1'b0;
        checkOutput("rst_valid", 32'(res_valid), 32'h0);
        checkOutput("rst_y", res_y, 32'h0);
        checkOutput("rst_id", 32'(res_id), 32'h0);
        contendCycle(1'b1);
        checkOutput("post_rst_id", 32'(res_id), 32'h0);
        idleCycle(1'b1);

        // Every op on every port.
        for (int p = 0; p < 2; p++) begin
            for (int o = 0; o < 8; o++) begin
                op = 3'(o);
                a  = $urandom;
                b  = (o >= 4 && o <= 6) ? 32'($urandom_range(0, 31)) : $urandom;
                if (p == 0)
                    applyStimulus(1'b1, a, b, op, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
                else
                    applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, a, b, op, 1'b1);
                if (o == 7) begin
                    checkOutput("op_zero_y", res_y, 32'h0);
                    checkOutput("op_zero_id", 32'(res_id), 32'(p));
                end
            end
        end

        // Random mix of valids, ops and backpressure.
        for (int i = 0; i < 60; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            applyStimulus(v0, $urandom, 32'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                          v1, $urandom, 32'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                          rr);
        end
        idleCycle(1'b1);
        idleCycle(1'b1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_logic_arbiter.md
# alu_logic_arbiter

Shares one `ALULogicModule` instance between two requesters (port 0 and port 1) using round-robin arbitration with valid/ready handshakes. Each accepted request is evaluated by the logic unit and captured in a single-entry result register. The result register is tagged with the requester ID and drained through one backpressured result port. The block sits between the two issue paths of the datapath and the shared logic/shift unit.

## Interface
- `bits`, 32, operand and result width; passed to the logic unit.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `req0_valid` input 1 — port 0 request present.
- `req0_ready` output 1 — port 0 request accepted this cycle when `req0_valid` is also high.
- `req0_a`, `req0_b` input `bits` — port 0 operands.
- `req0_op` input 3 — port 0 operation select.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op` — same as port 0, for port 1.
- `res_valid` output 1 — result register holds a result.
- `res_ready` input 1 — consumer takes the result this cycle when `res_valid` is also high.
- `res_y` output `bits` — registered result.
- `res_id` output 1 — requester that produced `res_y`.

## Operation
- Op encoding: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 LSL A by B, 101 LSR A by B, 110 ASR A by B, 111 zero. Semantics are those of the logic unit, unmodified.
- Output register states:
  - EMPTY (`res_valid`=0): can accept.
  - FULL (`res_valid`=1): can accept only if `res_ready`=1 in the same cycle, i.e. drain and refill together.
- `can_accept = !res_valid || res_ready`.
- Grant selection is combinational from the valids and the `last` pointer:
  - Only one valid: that port is granted.
  - Both valid: the port ≠ `last` is granted.
  - Neither valid: no grant.
- `reqN_ready = grantN && can_accept`. Ready is never asserted to a non-granted port. Ready may depend combinationally on `reqN_valid` and `res_ready`.
- Accept (granted valid && can_accept):
  - Operands and op of the granted port drive the logic unit.
  - `res_y` ← unit output, `res_id` ← granted port, `res_valid` ← 1.
  - `last` ← granted port.
- Drain without accept (`res_valid && res_ready`, no accept): `res_valid` ← 0. `res_y` and `res_id` hold their stale values.
- No accept and no drain: all state holds. A stalled result stays stable until taken.
- Requesters must hold `valid` and payload until ready. The block does not latch unaccepted payloads.
- `last` changes only on accept, never on a drain alone.

## Timing
- Latency: accept in cycle N → `res_valid`=1 with the result in cycle N+1.
- Throughput: one result per cycle while `res_ready`=1.
- Fairness: with both ports continuously valid and `res_ready`=1, grants alternate 0,1,0,1,…
- Backpressure: `res_ready`=0 while FULL → both readies 0; the held result is unchanged.
- Simultaneous drain and accept in one cycle: the new result replaces the old. No bubble, no loss.
- Reset, applied in any state including FULL:
  - Next cycle: `res_valid`=0, `res_y`=0, `res_id`=0, `last`=1 (port 0 wins the first contention).
  - `req0_ready`=`req1_ready`=0 while `rst`=1.
  - An in-flight result is discarded.
- No combinational path from `req*` payload to `res_*`.

## Structure
- Shared package `alu_logic_pkg`:
  - typedef `alu_logic_op_t` (3-bit enum, encodings above).
  - constant `ALU_LOGIC_OPS` = 8.
  - Used by this block and all issuers.
- One sub-module: `ALULogicModule #(bits)`. Its operand mux inputs are selected by the grant.
- Arbitration and the output register stay in the top block. No separate arbiter module.

## Test plan
- **Single port:** `req0` A=0xF0F0_F0F0, B=0x0FF0_0FF0, op=000 → cycle N+1: `res_valid`=1, `res_y`=0x00F0_00F0, `res_id`=0.
- **Contention after reset:** both ports valid (`req0` op=001 A=1 B=2; `req1` op=100 A=1 B=4), `res_ready`=1.
  - First result: `res_id`=0, `res_y`=3.
  - Next result: `res_id`=1, `res_y`=0x10.
  - Continued contention alternates IDs.
- **Backpressure:** `res_ready`=0 for 3 cycles while FULL (`res_y`=0x0000_00FF).
  - Both readies stay 0 and `res_y` is stable.
  - `res_ready`→1 with `req1` valid, op=110 A=0x8000_0000 B=4: same-cycle drain and refill, next `res_y`=0xF800_0000, `res_id`=1.
- **Drain only:** FULL, `res_ready`=1, no valids → next cycle `res_valid`=0. `last` is unchanged, verified by the next contention choosing the expected port.
- **Reset mid-operation:** assert `rst` while FULL with stalled `res_ready`=0 → next cycle `res_valid`=0, `res_y`=0, `res_id`=0. First post-reset contention grants port 0.
- **Op sweep:** random A/B over all 8 ops on both ports, compared against a reference model. Op 111 yields 0 and `res_id` matches the accepting port.
